// File: rtl/poop_deploy_scheduler.sv
// rtl/poop_deploy_scheduler.sv - one-hot poop deploy sequencer with ack timeout and frame cooldown
// Serves one queued drop request at a time into the lowest free slot, then holds off for a cooldown.
module poop_deploy_scheduler #(
  parameter int NUM_OF_POOPS    = 8,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic                                      clk,
  input  logic                                      resetN,
  input  logic                                      startOfFrame,
  input  logic                                      enable,
  input  logic                                      drop_request,
  input  logic signed [1:0][10:0]                   birdCoordinates,
  input  logic        [NUM_OF_POOPS-1:0]            slot_active,
  output logic        [NUM_OF_POOPS-1:0]            deploy_poop,
  output logic signed [NUM_OF_POOPS-1:0][1:0][10:0] initial_coordinates,
  output logic                                      cooldown_busy,
  output logic                                      deploy_fault,
  output logic        [7:0]                         drops_count
);
  localparam int SEL_W = (NUM_OF_POOPS > 1) ? $clog2(NUM_OF_POOPS) : 1;
  localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEPLOY   = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_COOLDOWN = 2'd3;

  logic [1:0]              state, state_nx;
  logic                    req_d, pending;
  logic [SEL_W-1:0]        sel, pick;
  logic [NUM_OF_POOPS-1:0] reserved, free;
  logic [CD_W-1:0]         cd_cnt;
  logic [TMR_W-1:0]        timer;
  logic                    rise, launch, ack_done, ack_expired, cd_done;

  assign rise        = drop_request & ~req_d;
  assign reserved    = (state == S_DEPLOY || state == S_WAIT_ACK) ? (NUM_OF_POOPS'(1) << sel) : '0;
  assign free        = ~slot_active & ~reserved;
  assign launch      = (state == S_IDLE) && pending && (|free);
  assign ack_done    = slot_active[sel];
  assign ack_expired = (timer == TMR_W'(ACK_TIMEOUT - 1));
  // The frame that brings the counter from 1 to 0 is the one that releases the cooldown.
  assign cd_done     = (COOLDOWN_FRAMES == 0) || (startOfFrame && cd_cnt <= CD_W'(1));

  always_comb begin
    pick = '0;
    for (int i = NUM_OF_POOPS - 1; i >= 0; i--) begin
      if (free[i]) pick = SEL_W'(i);
    end
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (launch) state_nx = S_DEPLOY;
        S_DEPLOY:   state_nx = S_WAIT_ACK;
        S_WAIT_ACK: if (ack_done || ack_expired) state_nx = S_COOLDOWN;
        default:    if (cd_done) state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state               <= S_IDLE;
      req_d               <= 1'b0;
      pending             <= 1'b0;
      sel                 <= '0;
      cd_cnt              <= '0;
      timer               <= '0;
      deploy_poop         <= '0;
      initial_coordinates <= '0;
      cooldown_busy       <= 1'b0;
      deploy_fault        <= 1'b0;
      drops_count         <= '0;
    end else begin
      state         <= state_nx;
      req_d         <= drop_request;
      cooldown_busy <= (state_nx == S_COOLDOWN);
      if (!enable) begin
        pending     <= 1'b0;
        cd_cnt      <= '0;
        timer       <= '0;
        deploy_poop <= '0;
      end else begin
        // An edge arriving as the queued request is consumed becomes the next queued request.
        if (launch) pending <= rise;
        else if (rise) pending <= 1'b1;
        case (state)
          S_IDLE: begin
            if (launch) begin
              sel                       <= pick;
              initial_coordinates[pick] <= birdCoordinates;
              deploy_poop               <= NUM_OF_POOPS'(1) << pick;
              if (drops_count != 8'hFF) drops_count <= drops_count + 8'd1;
            end
          end
          S_DEPLOY: begin
            deploy_poop <= '0;
            timer       <= '0;
          end
          S_WAIT_ACK: begin
            timer <= timer + TMR_W'(1);
            if (!ack_done && ack_expired) deploy_fault <= 1'b1;
            if (ack_done || ack_expired) cd_cnt <= CD_W'(COOLDOWN_FRAMES);
          end
          default: begin
            if (startOfFrame && cd_cnt != '0) cd_cnt <= cd_cnt - CD_W'(1);
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_poop_deploy_scheduler.sv
// tb/tb_poop_deploy_scheduler.sv - self-checking bench for poop_deploy_scheduler
// Main instance uses default parameters; a second instance with no cooldown exercises count saturation.
module tb_poop_deploy_scheduler;
  localparam int N  = 8;
  localparam int CD = 15;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0;
  logic enable = 1'b0;
  logic drop_request = 1'b0;
  logic drop_request_nc = 1'b0;
  logic signed [1:0][10:0] bird = '0;
  logic [N-1:0] slot_active = '0;
  logic [N-1:0] slot_active_nc = '0;

  logic [N-1:0] deploy_poop, deploy_poop_nc;
  logic signed [N-1:0][1:0][10:0] init_coords, init_coords_nc;
  logic busy, busy_nc, fault, fault_nc;
  logic [7:0] drops, drops_nc;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int p0, p1;

  always #5 clk = ~clk;

  poop_deploy_scheduler #(.NUM_OF_POOPS(N), .COOLDOWN_FRAMES(CD), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(enable),
    .drop_request(drop_request), .birdCoordinates(bird), .slot_active(slot_active),
    .deploy_poop(deploy_poop), .initial_coordinates(init_coords),
    .cooldown_busy(busy), .deploy_fault(fault), .drops_count(drops)
  );

  poop_deploy_scheduler #(.NUM_OF_POOPS(N), .COOLDOWN_FRAMES(0), .ACK_TIMEOUT(TO)) dut_nc (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(enable),
    .drop_request(drop_request_nc), .birdCoordinates(bird), .slot_active(slot_active_nc),
    .deploy_poop(deploy_poop_nc), .initial_coordinates(init_coords_nc),
    .cooldown_busy(busy_nc), .deploy_fault(fault_nc), .drops_count(drops_nc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one request in flight, tracked as "which slot, pulse phase, clocks waited, frames left".
  bit m_req_prev, m_pending, m_in_deploy, m_cooling, m_fault;
  int m_sel, m_wait, m_frames_left, m_count;
  logic [N-1:0] m_deploy;
  logic signed [1:0][10:0] m_coords [N];

  always @(posedge clk or negedge resetN) begin : model
    bit rise;
    int pick;
    if (!resetN) begin
      m_req_prev = 0; m_pending = 0; m_in_deploy = 0; m_cooling = 0; m_fault = 0;
      m_sel = -1; m_wait = 0; m_frames_left = 0; m_count = 0; m_deploy = '0;
      for (int i = 0; i < N; i++) m_coords[i] = '0;
    end else begin
      rise = drop_request && !m_req_prev;
      m_req_prev = drop_request;
      if (!enable) begin
        m_pending = 0; m_in_deploy = 0; m_cooling = 0; m_sel = -1; m_deploy = '0;
      end else if (m_sel < 0 && !m_cooling) begin
        pick = -1;
        for (int i = 0; i < N; i++) if (!slot_active[i] && pick < 0) pick = i;
        if (m_pending && pick >= 0) begin
          m_sel = pick;
          m_coords[pick] = bird;
          m_deploy = '0;
          m_deploy[pick] = 1'b1;
          m_in_deploy = 1;
          m_count = (m_count < 255) ? m_count + 1 : 255;
          m_pending = rise;
        end else if (rise) begin
          m_pending = 1;
        end
      end else begin
        if (rise) m_pending = 1;
        if (m_in_deploy) begin
          m_in_deploy = 0; m_deploy = '0; m_wait = 0;
        end else if (m_sel >= 0) begin
          if (slot_active[m_sel] || m_wait == TO - 1) begin
            if (!slot_active[m_sel]) m_fault = 1;
            m_sel = -1; m_cooling = 1; m_frames_left = CD;
          end else begin
            m_wait++;
          end
        end else if (sof) begin
          m_frames_left--;
          if (m_frames_left == 0) m_cooling = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (deploy_poop != '0) pulses++;
    chk("deploy", deploy_poop, m_deploy);
    chk("busy", busy, m_cooling);
    chk("fault", fault, m_fault);
    chk("count", drops, m_count[7:0]);
    for (int i = 0; i < N; i++) chk($sformatf("coord%0d", i), {init_coords[i]}, {m_coords[i]});
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic frame();
    sof = 1'b1; tick(); sof = 1'b0; tick(2);
  endtask

  task automatic rise_req();
    drop_request = 1'b1; tick(); drop_request = 1'b0;
  endtask

  task automatic drain_cooldown(input string name);
    for (int i = 0; i < 40 && busy; i++) frame();
    chk(name, busy, 1'b0);
  endtask

  initial begin
    tick(2);
    chk("rst_deploy", deploy_poop, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_count", drops, 8'd0);
    chk("rst_coord0", {init_coords[0]}, 22'd0);

    resetN = 1'b1; enable = 1'b1; bird[0] = 11'd100; bird[1] = 11'd50;
    tick();
    rise_req();
    chk("t1_pending_only", deploy_poop, 8'h00);
    tick();
    chk("t1_pulse", deploy_poop, 8'h01);
    chk("t1_x", init_coords[0][0], 11'd100);
    chk("t1_y", init_coords[0][1], 11'd50);
    chk("t1_count", drops, 8'd1);
    tick();
    chk("t1_pulse_end", deploy_poop, 8'h00);
    slot_active = 8'h01;
    tick();
    chk("t1_busy", busy, 1'b1);
    drain_cooldown("t1_drain");

    slot_active = 8'h07; bird[0] = 11'h7EC; bird[1] = 11'd700;
    rise_req();
    tick();
    chk("t2_pulse", deploy_poop, 8'h08);
    chk("t2_x", init_coords[3][0], 11'h7EC);
    chk("t2_y", init_coords[3][1], 11'd700);
    chk("t2_slot0_held", init_coords[0][0], 11'd100);
    tick();
    slot_active = 8'h0F;
    tick();
    chk("t2_busy", busy, 1'b1);
    for (int i = 0; i < CD - 1; i++) begin
      frame();
      chk("t2_busy_hold", busy, 1'b1);
    end
    frame();
    chk("t2_busy_done", busy, 1'b0);
    chk("t2_fault", fault, 1'b0);
    chk("t2_count", drops, 8'd2);

    slot_active = 8'hFF; bird[0] = 11'd5; bird[1] = 11'h7FF;
    rise_req();
    tick(4);
    chk("t3_blocked", deploy_poop, 8'h00);
    chk("t3_count_held", drops, 8'd2);
    slot_active = 8'hDF;
    tick();
    chk("t3_pulse", deploy_poop, 8'h20);
    chk("t3_y", init_coords[5][1], 11'h7FF);
    chk("t3_count", drops, 8'd3);

    tick();
    tick(3);
    chk("t4_no_fault_yet", fault, 1'b0);
    tick();
    chk("t4_fault", fault, 1'b1);
    chk("t4_busy", busy, 1'b1);

    p0 = pulses;
    drop_request = 1'b1; tick(); drop_request = 1'b0; tick();
    drop_request = 1'b1; tick(); drop_request = 1'b0;
    drain_cooldown("t5_drain");
    slot_active = 8'hFF;
    tick();
    chk("t5_one_deploy", pulses - p0, 1);
    chk("t5_count", drops, 8'd4);
    chk("t5_fault_sticky", fault, 1'b1);
    chk("t5_busy", busy, 1'b1);
    p1 = pulses;
    rise_req();
    enable = 1'b0;
    tick();
    chk("t5_abort_busy", busy, 1'b0);
    enable = 1'b1; slot_active = 8'h00;
    tick(4);
    chk("t5_no_pulse", pulses - p1, 0);
    chk("t5_count_held", drops, 8'd4);

    bird[0] = 11'd9; bird[1] = 11'd9;
    rise_req();
    tick();
    chk("t6_pulse", deploy_poop, 8'h01);
    resetN = 1'b0;
    #1;
    chk("t6_async_deploy", deploy_poop, 8'h00);
    chk("t6_async_count", drops, 8'd0);
    chk("t6_async_fault", fault, 1'b0);
    tick(2);
    resetN = 1'b1;
    tick();

    chk("t7_start", drops_nc, 8'd0);
    for (int k = 1; k <= 300; k++) begin
      drop_request_nc = 1'b1; tick(); drop_request_nc = 1'b0; tick(11);
      if (k == 100) chk("t7_count100", drops_nc, 8'd100);
    end
    chk("t7_saturated", drops_nc, 8'd255);
    chk("t7_fault", fault_nc, 1'b1);
    chk("t7_main_quiet", drops, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
